// File: rtl/regfile_client_async_rst.sv
// Request front end for a 1R/1W register file with a buffered, backpressured read-response FIFO.
// Optional post-reset init sweep is compiled in when REGFILE_CLIENT_INIT_EN is defined.
module regfile_client_async_rst #(
    parameter int unsigned      WIDTH      = 8,
    parameter int unsigned      N_REG      = 8,
    parameter int unsigned      RSP_DEPTH  = 2,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [$clog2(N_REG)-1:0] req_addr,
    input  logic [WIDTH-1:0]         req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_rdata,
    output logic [$clog2(N_REG)-1:0] rf_raddr,
    input  logic [WIDTH-1:0]         rf_rdata,
    output logic [$clog2(N_REG)-1:0] rf_waddr,
    output logic                     rf_wen,
    output logic [WIDTH-1:0]         rf_wdata
);
    localparam int unsigned AW = $clog2(N_REG);
    localparam int unsigned PW = $clog2(RSP_DEPTH);
    localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

    logic [WIDTH-1:0] fifo_mem [RSP_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             idle;
    logic             init_wen;
    logic [AW-1:0]    init_addr;
    logic             push;
    logic             pop;

`ifdef REGFILE_CLIENT_INIT_EN
    typedef enum logic {INIT, IDLE} state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] init_cnt;
    logic [AW-1:0] init_cnt_next;

    // Sweep state and counter; the counter parks on the last index once the sweep ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_next;
            init_cnt <= init_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        init_cnt_next = init_cnt;
        idle          = 1'b0;
        init_wen      = 1'b0;
        init_addr     = init_cnt;
        case (state)
            INIT: begin
                init_wen = 1'b1;
                if (init_cnt == AW'(N_REG - 1)) begin
                    state_next = IDLE;
                end else begin
                    init_cnt_next = init_cnt + AW'(1);
                end
            end
            IDLE: idle = 1'b1;
            default: state_next = INIT;
        endcase
    end
`else
    assign idle      = 1'b1;
    assign init_wen  = 1'b0;
    assign init_addr = '0;
`endif

    // Response side is a pure function of FIFO state.
    assign rsp_valid = (count != '0);
    assign rsp_rdata = rsp_valid ? fifo_mem[rd_ptr] : '0;
    assign pop       = rsp_valid & rsp_ready;

    // Request side: a full FIFO still takes a read when a response leaves in the same cycle.
    always_comb begin
        req_ready = 1'b0;
        rf_wen    = 1'b0;
        rf_waddr  = '0;
        rf_raddr  = '0;
        rf_wdata  = req_wdata;
        push      = 1'b0;
        if (!rst) begin
            if (idle) begin
                req_ready = req_we | (count < CW'(RSP_DEPTH)) | rsp_ready;
                rf_waddr  = req_addr;
                rf_raddr  = req_addr;
                rf_wen    = req_valid & req_ready & req_we;
                push      = req_valid & req_ready & ~req_we;
            end else begin
                rf_wen    = init_wen;
                rf_waddr  = init_addr;
                rf_wdata  = INIT_VALUE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset; count gates visibility.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= rf_rdata;
    end
endmodule
